// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader.
// State encoding, word geometry and default sizes.
`timescale 1ns/1ps
package program_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam int BYTES_PER_WORD    = 4;
    localparam int IDX_W             = $clog2(BYTES_PER_WORD);
    localparam int DEFAULT_MAX_WORDS = 256;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Little-endian byte-to-word assembler for the program loader.
// Holds the lane shift register, byte index and running checksum.
`timescale 1ns/1ps
module loader_word_assembler
    import program_loader_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_clear,
    input  logic                        i_en,
    input  logic [7:0]                  i_byte,
    output logic [8*BYTES_PER_WORD-1:0] o_word,
    output logic                        o_word_full,
    output logic [7:0]                  o_checksum
);

    logic [IDX_W-1:0]            r_idx;
    logic [8*BYTES_PER_WORD-1:0] r_word;
    logic [7:0]                  r_sum;

    // Place each accepted byte in its lane and fold it into the checksum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_word <= '0;
            r_sum  <= '0;
        end else if (i_clear) begin
            r_idx  <= '0;
            r_word <= '0;
            r_sum  <= '0;
        end else if (i_en) begin
            r_word[8*r_idx +: 8] <= i_byte;
            r_idx                <= r_idx + IDX_W'(1);
            r_sum                <= r_sum + i_byte;
        end
    end

    assign o_word      = r_word;
    assign o_checksum  = r_sum;
    assign o_word_full = i_en && (r_idx == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader that fills instruction memory.
// Keeps the CPU held until a frame with a good checksum lands.
`timescale 1ns/1ps
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WORDS  = DEFAULT_MAX_WORDS
) (
    input  logic                  MAX10_CLK1_50,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] rom_wr_address,
    output logic [DATA_WIDTH-1:0] rom_wr_data,
    output logic                  rom_wr_en,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam logic [16:0] MAXW = 17'(MAX_WORDS);

    state_t                r_state;
    state_t                w_next;
    logic [7:0]            r_len_lo;
    logic [15:0]           r_len;
    logic [ADDR_WIDTH:0]   r_word_count;
    logic [ADDR_WIDTH:0]   w_wc_inc;
    logic [15:0]           w_len_full;
    logic                  w_len_bad;
    logic                  w_xfer;
    logic                  w_clear;
    logic                  w_asm_en;
    logic                  w_word_full;
    logic [7:0]            w_checksum;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_xfer     = rx_valid && rx_ready;
    assign w_asm_en   = w_xfer && (r_state == S_DATA);
    assign w_len_full = {rx_data, r_len_lo};
    assign w_len_bad  = (w_len_full == 16'd0) ||
                        ({1'b0, w_len_full} > MAXW);
    assign w_wc_inc   = r_word_count + (ADDR_WIDTH+1)'(1);

    loader_word_assembler u_asm (
        .clk         (MAX10_CLK1_50),
        .rst_n       (reset),
        .i_clear     (w_clear),
        .i_en        (w_asm_en),
        .i_byte      (rx_data),
        .o_word      (w_word),
        .o_word_full (w_word_full),
        .o_checksum  (w_checksum)
    );

    // State register
    always_ff @(posedge MAX10_CLK1_50 or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and per-state output decode
    always_comb begin
        w_next    = r_state;
        rx_ready  = 1'b0;
        rom_wr_en = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        cpu_hold  = 1'b1;
        w_clear   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next  = S_LEN_LO;
                    w_clear = 1'b1;
                end
            end
            S_LEN_LO: begin
                busy     = 1'b1;
                rx_ready = 1'b1;
                if (w_xfer) w_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                busy     = 1'b1;
                rx_ready = 1'b1;
                if (w_xfer) w_next = w_len_bad ? S_ERROR : S_DATA;
            end
            S_DATA: begin
                busy     = 1'b1;
                rx_ready = 1'b1;
                if (w_word_full) w_next = S_WRITE;
            end
            S_WRITE: begin
                busy      = 1'b1;
                rom_wr_en = 1'b1;
                w_next    = (16'(w_wc_inc) == r_len) ? S_CHECK : S_DATA;
            end
            S_CHECK: begin
                busy     = 1'b1;
                rx_ready = 1'b1;
                if (w_xfer) begin
                    w_next = (rx_data == w_checksum) ? S_DONE : S_ERROR;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) begin
                    w_next  = S_LEN_LO;
                    w_clear = 1'b1;
                end
            end
            S_ERROR: begin
                error = 1'b1;
                if (start) begin
                    w_next  = S_LEN_LO;
                    w_clear = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Latch the frame length as its two bytes arrive
    always_ff @(posedge MAX10_CLK1_50 or negedge reset) begin
        if (!reset) begin
            r_len_lo <= '0;
            r_len    <= '0;
        end else if (w_xfer && r_state == S_LEN_LO) begin
            r_len_lo <= rx_data;
        end else if (w_xfer && r_state == S_LEN_HI) begin
            r_len    <= w_len_full;
        end
    end

    // Count written words; doubles as the write address
    always_ff @(posedge MAX10_CLK1_50 or negedge reset) begin
        if (!reset)         r_word_count <= '0;
        else if (w_clear)   r_word_count <= '0;
        else if (rom_wr_en) r_word_count <= w_wc_inc;
    end

    assign rom_wr_address = r_word_count[ADDR_WIDTH-1:0];
    assign rom_wr_data    = w_word;
    assign word_count     = r_word_count;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader.
// Stimulus queues expected writes; a monitor checks every strobe.
`timescale 1ns/1ps
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  rom_wr_address;
    logic [31:0] rom_wr_data;
    logic        rom_wr_en;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  word_count;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_pass   = 0;

    program_loader dut (
        .MAX10_CLK1_50  (clk),
        .reset          (reset),
        .start          (start),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .rom_wr_address (rom_wr_address),
        .rom_wr_data    (rom_wr_data),
        .rom_wr_en      (rom_wr_en),
        .cpu_hold       (cpu_hold),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .word_count     (word_count)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (rom_wr_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no strobe",
                             rom_wr_address, rom_wr_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", 32'(rom_wr_address), 32'(mon_e.addr));
                    check("wr_data", rom_wr_data, mon_e.data);
                end
            end
            if (busy) check("rx_ready_only_low_in_write",
                            32'(rx_ready), 32'(!rom_wr_en));
        end
    end

    task automatic push(input logic [7:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            $display("FAIL send_timeout: rx_ready got 0 expected 1");
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8], gap);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_wr_en"}, 32'(rom_wr_en), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_addr"}, 32'(rom_wr_address), 32'd0);
        check({tag, "_data"}, rom_wr_data, 32'd0);
        check({tag, "_wc"}, 32'(word_count), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle(3);
        check_reset_vals("por");
        reset = 1'b1;
        idle(2);

        // Two-word frame, good checksum (0x13+0x93+0x50 = 0xF6)
        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        send(8'h02, 0);
        send(8'h00, 0);
        push(8'd0, 32'h0000_0013);
        push(8'd1, 32'h0050_0093);
        send_word(32'h0000_0013, 0);
        send_word(32'h0050_0093, 0);
        send(8'hF6, 0);
        idle(2);
        check("good_done", 32'(done), 32'd1);
        check("good_hold", 32'(cpu_hold), 32'd0);
        check("good_wc", 32'(word_count), 32'd2);
        check("good_err", 32'(error), 32'd0);

        // Start from DONE re-holds the CPU at the next edge
        pulse_start();
        check("restart_hold", 32'(cpu_hold), 32'd1);
        check("restart_done", 32'(done), 32'd0);
        check("restart_wc", 32'(word_count), 32'd0);

        // Same frame, bad checksum
        send(8'h02, 0);
        send(8'h00, 0);
        push(8'd0, 32'h0000_0013);
        push(8'd1, 32'h0050_0093);
        send_word(32'h0000_0013, 0);
        send_word(32'h0050_0093, 0);
        send(8'h00, 0);
        idle(2);
        check("badchk_err", 32'(error), 32'd1);
        check("badchk_hold", 32'(cpu_hold), 32'd1);
        check("badchk_done", 32'(done), 32'd0);
        check("badchk_wc", 32'(word_count), 32'd2);

        // Zero length
        pulse_start();
        send(8'h00, 0);
        send(8'h00, 0);
        idle(2);
        check("len0_err", 32'(error), 32'd1);
        check("len0_wc", 32'(word_count), 32'd0);
        check("len0_ready", 32'(rx_ready), 32'd0);

        // Length 257 exceeds MAX_WORDS
        pulse_start();
        send(8'h01, 0);
        send(8'h01, 0);
        idle(2);
        check("len257_err", 32'(error), 32'd1);
        check("len257_hold", 32'(cpu_hold), 32'd1);

        // One word with 3-cycle gaps (checksum 0x38)
        pulse_start();
        send(8'h01, 3);
        send(8'h00, 3);
        push(8'd0, 32'hDEAD_BEEF);
        send_word(32'hDEAD_BEEF, 3);
        send(8'h38, 3);
        idle(2);
        check("gap_done", 32'(done), 32'd1);
        check("gap_wc", 32'(word_count), 32'd1);

        // Reset after five payload bytes
        pulse_start();
        send(8'h02, 0);
        send(8'h00, 0);
        push(8'd0, 32'h4433_2211);
        send_word(32'h4433_2211, 0);
        send(8'h55, 0);
        idle(1);
        reset = 1'b0;
        #1;
        check_reset_vals("midrst");
        idle(2);
        reset = 1'b1;
        idle(1);

        // Full frame after reset, start pulsed during DATA
        pulse_start();
        send(8'h01, 0);
        send(8'h00, 0);
        push(8'd0, 32'hDEAD_BEEF);
        send(8'hEF, 0);
        send(8'hBE, 0);
        pulse_start();
        check("start_in_data_busy", 32'(busy), 32'd1);
        send(8'hAD, 0);
        send(8'hDE, 0);
        send(8'h38, 0);
        idle(2);
        check("after_rst_done", 32'(done), 32'd1);
        check("after_rst_hold", 32'(cpu_hold), 32'd0);
        check("after_rst_wc", 32'(word_count), 32'd1);

        idle(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
